// File: rtl/vmem_arbiter_if.sv
// Bus bundle between the vector data memory arbiter and its surroundings:
// the MEM-stage CPU port, the host burst port and the data_mem port.
// Handshake: host_start is a one-cycle request sampled only while the
// arbiter is idle; each host_beat marks one beat taken (host_wdata consumed
// on that cycle for writes, host_rdata/host_rvalid presented the cycle after
// for reads); host_done closes the burst. cpu_stall=1 means the CPU access
// offered this cycle was not performed and must be held.
interface vmem_arbiter_if #(
  parameter int I  = 32,
  parameter int N  = 8,
  parameter int R  = 6,
  parameter int LW = 8
);
  logic           cpu_req;
  logic           cpu_we;
  logic [I-1:0]   cpu_addr;
  logic [R*N-1:0] cpu_wdata;
  logic [R*N-1:0] cpu_rdata;
  logic           cpu_stall;

  logic           host_start;
  logic           host_we;
  logic [I-1:0]   host_base;
  logic [LW-1:0]  host_len;
  logic [R*N-1:0] host_wdata;
  logic           host_busy;
  logic           host_beat;
  logic [R*N-1:0] host_rdata;
  logic           host_rvalid;
  logic           host_done;

  logic           mem_we;
  logic [I-1:0]   mem_a;
  logic [R*N-1:0] mem_wd;
  logic [R*N-1:0] mem_rd;

  // FSM state for observation (0 idle, 1 burst, 2 done)
  logic [1:0]     fsm_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_start, host_we, host_base, host_len, host_wdata,
    output host_busy, host_beat, host_rdata, host_rvalid, host_done,
    output mem_we, mem_a, mem_wd,
    input  mem_rd,
    output fsm_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_start, host_we, host_base, host_len, host_wdata,
    input  host_busy, host_beat, host_rdata, host_rvalid, host_done,
    input  mem_we, mem_a, mem_wd,
    output mem_rd,
    input  fsm_state
  );
endinterface

// File: rtl/vmem_arbiter.sv
// Vector data memory arbiter: shares one R-lane memory between the pipeline
// MEM stage and a host burst port. During a host burst the CPU keeps the
// memory unless it has already won STARVE cycles in a row, after which the
// host takes one beat and the CPU is stalled for that cycle.
module vmem_arbiter #(
  parameter int I      = 32,
  parameter int N      = 8,
  parameter int R      = 6,
  parameter int LW     = 8,
  parameter int STARVE = 4
) (
  input logic          clk,
  input logic          reset,
  vmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SW = $clog2(STARVE + 1);

  state_t         state, state_nx;
  logic [SW-1:0]  starve_cnt, starve_nx;
  logic [I-1:0]   cur_addr;
  logic [LW-1:0]  remaining;
  logic           dir;
  logic           host_grant;
  logic [R*N-1:0] host_rdata_q;
  logic           host_rvalid_q;

  // State register; reset drops any burst in flight without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
    end
  end

  // Next state, grant decision and starvation counting
  always_comb begin
    state_nx   = state;
    starve_nx  = '0;
    host_grant = 1'b0;
    case (state)
      IDLE: begin
        if (bus.host_start)
          state_nx = (bus.host_len == '0) ? DONE : BURST;
      end
      BURST: begin
        if (bus.cpu_req && (starve_cnt < SW'(STARVE))) begin
          starve_nx = starve_cnt + 1'b1;
        end else begin
          host_grant = 1'b1;
          if (remaining == LW'(1))
            state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Burst context: latched on an accepted start, stepped on each host beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      dir       <= 1'b0;
    end else if ((state == IDLE) && bus.host_start) begin
      cur_addr  <= bus.host_base;
      remaining <= bus.host_len;
      dir       <= bus.host_we;
    end else if (host_grant) begin
      cur_addr  <= cur_addr + I'(R);
      remaining <= remaining - 1'b1;
    end
  end

  // Host read data is captured from the beat and presented one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= host_grant && !dir;
      if (host_grant && !dir)
        host_rdata_q <= bus.mem_rd;
    end
  end

  assign bus.mem_a       = host_grant ? cur_addr : bus.cpu_addr;
  assign bus.mem_we      = host_grant ? dir : (bus.cpu_we & bus.cpu_req);
  assign bus.mem_wd      = host_grant ? bus.host_wdata : bus.cpu_wdata;
  assign bus.cpu_rdata   = bus.mem_rd;
  assign bus.cpu_stall   = bus.cpu_req & host_grant;
  assign bus.host_busy   = (state == BURST);
  assign bus.host_beat   = host_grant;
  assign bus.host_done   = (state == DONE);
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter with a small behavioural data memory.
module tb_vmem_arbiter;

  localparam int I = 32, N = 8, R = 6, LW = 8, STARVE = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  vmem_arbiter_if #(.I(I), .N(N), .R(R), .LW(LW)) bus ();

  vmem_arbiter #(.I(I), .N(N), .R(R), .LW(LW), .STARVE(STARVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // data memory: combinational read, write on rising edge, low 8 address bits
  logic [R*N-1:0] mem [256];
  assign bus.mem_rd = mem[bus.mem_a[7:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;

  logic [R*N-1:0] wd [3];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   64'(bus.host_busy),   64'd0);
    chk({tag, "_beat"},   64'(bus.host_beat),   64'd0);
    chk({tag, "_rvalid"}, 64'(bus.host_rvalid), 64'd0);
    chk({tag, "_done"},   64'(bus.host_done),   64'd0);
    chk({tag, "_rdata"},  64'(bus.host_rdata),  64'd0);
    chk({tag, "_state"},  64'(bus.fsm_state),   64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wd[0] = 48'h1111_2222_3333;
    wd[1] = 48'h4444_5555_6666;
    wd[2] = 48'h7777_8888_9999;
    reset          = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.host_start = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_base  = '0;
    bus.host_len   = '0;
    bus.host_wdata = '0;

    // reset state
    tick(); tick(); #1;
    chk_idle_outputs("reset");
    chk("reset_stall", 64'(bus.cpu_stall), 64'd0);
    reset = 1'b0;

    // host write burst 0x100, len 3, no CPU traffic
    tick();
    bus.host_start = 1'b1; bus.host_we = 1'b1; bus.host_base = 32'h100; bus.host_len = 8'd3;
    #1 chk("wr_start_busy", 64'(bus.host_busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.host_start = 1'b0; bus.host_wdata = wd[i];
      #1;
      chk("wr_beat",  64'(bus.host_beat), 64'd1);
      chk("wr_addr",  64'(bus.mem_a),     64'h100 + 64'(6 * i));
      chk("wr_we",    64'(bus.mem_we),    64'd1);
      chk("wr_wd",    64'(bus.mem_wd),    64'(wd[i]));
      chk("wr_busy",  64'(bus.host_busy), 64'd1);
      chk("wr_stall", 64'(bus.cpu_stall), 64'd0);
    end
    tick(); #1;
    chk("wr_done",      64'(bus.host_done), 64'd1);
    chk("wr_done_busy", 64'(bus.host_busy), 64'd0);
    chk("wr_done_beat", 64'(bus.host_beat), 64'd0);
    chk("wr_done_st",   64'(bus.fsm_state), 64'd2);
    tick(); #1;
    chk("wr_after_done", 64'(bus.host_done), 64'd0);
    chk("wr_after_st",   64'(bus.fsm_state), 64'd0);

    // host read burst over the same words
    tick();
    bus.host_start = 1'b1; bus.host_we = 1'b0; bus.host_base = 32'h100; bus.host_len = 8'd3;
    tick(); bus.host_start = 1'b0; #1;
    chk("rd_beat0",   64'(bus.host_beat),   64'd1);
    chk("rd_we0",     64'(bus.mem_we),      64'd0);
    chk("rd_rvalid0", 64'(bus.host_rvalid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("rd_beat",   64'(bus.host_beat),   64'd1);
      chk("rd_addr",   64'(bus.mem_a),       64'h106 + 64'(6 * i));
      chk("rd_rvalid", 64'(bus.host_rvalid), 64'd1);
      chk("rd_rdata",  64'(bus.host_rdata),  64'(wd[i]));
    end
    tick(); #1;
    chk("rd_done",        64'(bus.host_done),   64'd1);
    chk("rd_last_rvalid", 64'(bus.host_rvalid), 64'd1);
    chk("rd_last_rdata",  64'(bus.host_rdata),  64'(wd[2]));
    tick(); #1;
    chk("rd_done_once", 64'(bus.host_done),   64'd0);
    chk("rd_rvalid_off", 64'(bus.host_rvalid), 64'd0);

    // CPU write then read while idle
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h50; bus.cpu_wdata = 48'hC0FF_EE12_3456;
    #1;
    chk("cpu_wr_we",    64'(bus.mem_we),    64'd1);
    chk("cpu_wr_addr",  64'(bus.mem_a),     64'h50);
    chk("cpu_wr_wd",    64'(bus.mem_wd),    64'hC0FF_EE12_3456);
    chk("cpu_wr_stall", 64'(bus.cpu_stall), 64'd0);
    tick();
    bus.cpu_we = 1'b0;
    #1 chk("cpu_rd_data", 64'(bus.cpu_rdata), 64'hC0FF_EE12_3456);

    // burst len 2 under continuous CPU requests: 4 CPU cycles then 1 host beat
    tick();
    bus.cpu_addr = 32'h40;
    bus.host_start = 1'b1; bus.host_we = 1'b1; bus.host_base = 32'h20; bus.host_len = 8'd2;
    #1 chk("st_start_stall", 64'(bus.cpu_stall), 64'd0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick(); bus.host_start = 1'b0; #1;
        chk("st_cpu_beat",  64'(bus.host_beat), 64'd0);
        chk("st_cpu_stall", 64'(bus.cpu_stall), 64'd0);
        chk("st_cpu_addr",  64'(bus.mem_a),     64'h40);
        chk("st_cpu_busy",  64'(bus.host_busy), 64'd1);
      end
      tick(); bus.host_wdata = wd[k]; #1;
      chk("st_host_beat",  64'(bus.host_beat), 64'd1);
      chk("st_host_stall", 64'(bus.cpu_stall), 64'd1);
      chk("st_host_addr",  64'(bus.mem_a),     64'h20 + 64'(6 * k));
      chk("st_host_we",    64'(bus.mem_we),    64'd1);
    end
    tick(); #1;
    chk("st_done",       64'(bus.host_done), 64'd1);
    chk("st_done_stall", 64'(bus.cpu_stall), 64'd0);
    bus.cpu_req = 1'b0;

    // zero-length burst goes straight to DONE
    tick();
    bus.host_start = 1'b1; bus.host_we = 1'b1; bus.host_base = 32'h200; bus.host_len = 8'd0;
    tick(); bus.host_start = 1'b0; #1;
    chk("len0_done", 64'(bus.host_done), 64'd1);
    chk("len0_busy", 64'(bus.host_busy), 64'd0);
    chk("len0_beat", 64'(bus.host_beat), 64'd0);
    chk("len0_we",   64'(bus.mem_we),    64'd0);
    tick(); #1;
    chk("len0_idle", 64'(bus.fsm_state), 64'd0);

    // address wrap at the top of the address space
    tick();
    bus.host_start = 1'b1; bus.host_we = 1'b1; bus.host_base = 32'hFFFF_FFFC; bus.host_len = 8'd2;
    tick(); bus.host_start = 1'b0; #1;
    chk("wrap_a0", 64'(bus.mem_a), 64'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_a1", 64'(bus.mem_a), 64'h0000_0002);
    tick(); #1;
    chk("wrap_done", 64'(bus.host_done), 64'd1);

    // reset mid-burst: read of 4 beats interrupted after rdata is loaded
    tick();
    bus.host_start = 1'b1; bus.host_we = 1'b0; bus.host_base = 32'h100; bus.host_len = 8'd4;
    tick(); bus.host_start = 1'b0;
    tick(); #1;
    chk("mid_rvalid", 64'(bus.host_rvalid), 64'd1);
    chk("mid_rdata",  64'(bus.host_rdata),  64'(wd[0]));
    reset = 1'b1;
    #1 chk_idle_outputs("mid_reset");
    tick(); reset = 1'b0; #1;
    chk("post_rst_done", 64'(bus.host_done), 64'd0);
    tick(); #1;
    chk("post_rst_done2", 64'(bus.host_done), 64'd0);
    chk("post_rst_beat",  64'(bus.host_beat), 64'd0);

    // full burst after reset
    tick();
    bus.host_start = 1'b1; bus.host_we = 1'b0; bus.host_base = 32'h100; bus.host_len = 8'd3;
    for (int i = 0; i < 3; i++) begin
      tick(); bus.host_start = 1'b0; #1;
      chk("again_beat", 64'(bus.host_beat), 64'd1);
      chk("again_addr", 64'(bus.mem_a),     64'h100 + 64'(6 * i));
    end
    tick(); #1;
    chk("again_done",  64'(bus.host_done),  64'd1);
    chk("again_rdata", 64'(bus.host_rdata), 64'(wd[2]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
